sc_colision_nv: RTL

- Downstream consumer of the vehicle-level lane registers.
- Each cycle it samples the NUM_LANES parallel lane buses against the frog's row/column, detects a frog-vehicle overlap and manages the life counter.
- On collision it issues a respawn request with a blanking window. It also flags game over.
- It pulses a level-complete strobe when the frog reaches the goal row; that strobe feeds the level-change input of the lane stage.

---
 rtl/sc_colision_nv.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sc_colision_nv.sv
// Frog/vehicle collision checker: compares the frog position against the lane buses,
// manages lives, post-hit blanking, game over and the level-complete strobe.
module sc_colision_nv_lane #(
  parameter int LANE_ROW      = 1,
  parameter int DATAWIDTH_BUS = 8
) (
  input  logic [DATAWIDTH_BUS-1:0] bus,
  input  logic [2:0]               row,
  input  logic [2:0]               col,
  output logic                     hit
);
  // Columns beyond the bus never match, so out-of-range COL reads as empty road.
  always_comb begin
    hit = 1'b0;
    for (int c = 0; c < DATAWIDTH_BUS; c++)
      if (row == 3'(LANE_ROW) && col == 3'(c) && bus[c]) hit = 1'b1;
  end
endmodule

module sc_colision_nv #(
  parameter int                          DATAWIDTH_BUS    = 8,
  parameter int                          NUM_LANES        = 4,
  parameter int                          DATAWIDTH_ESTADO = 3,
  parameter int                          DATAWIDTH_VIDAS  = 2,
  parameter int                          VIDAS_INIT       = 3,
  parameter int                          BLANK_CYCLES     = 8,
  parameter logic [DATAWIDTH_ESTADO-1:0] ESTADO_INICIO    = 3'd0,
  parameter logic [DATAWIDTH_ESTADO-1:0] ESTADO_JUEGO     = 3'd1
) (
  input  logic                               SC_COLISION_NV_CLOCK,
  input  logic                               SC_COLISION_NV_RESET,
  input  logic [DATAWIDTH_ESTADO-1:0]        SC_COLISION_NV_ESTADO_IN,
  input  logic [NUM_LANES*DATAWIDTH_BUS-1:0] SC_COLISION_NV_LANES_IN,
  input  logic [2:0]                         SC_COLISION_NV_FROG_ROW_IN,
  input  logic [2:0]                         SC_COLISION_NV_FROG_COL_IN,
  output logic                               SC_COLISION_NV_COLISION_OUT,
  output logic                               SC_COLISION_NV_RESPAWN_OUT,
  output logic                               SC_COLISION_NV_META_OUT,
  output logic [DATAWIDTH_VIDAS-1:0]         SC_COLISION_NV_VIDAS_OUT,
  output logic                               SC_COLISION_NV_GAMEOVER_OUT
);
  localparam int CNT_W = $clog2(BLANK_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARMED, BLANK, GOAL, OVER} state_t;

  state_t                                 state;
  logic [CNT_W-1:0]                       cnt;
  logic [NUM_LANES-1:0][DATAWIDTH_BUS-1:0] lanes;
  logic [NUM_LANES-1:0]                   lane_hit;
  logic                                   juego, inicio, hit_raw, goal_raw, last_life;

  assign lanes = SC_COLISION_NV_LANES_IN;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    sc_colision_nv_lane #(.LANE_ROW(k + 1), .DATAWIDTH_BUS(DATAWIDTH_BUS)) u_lane (
      .bus (lanes[k]),
      .row (SC_COLISION_NV_FROG_ROW_IN),
      .col (SC_COLISION_NV_FROG_COL_IN),
      .hit (lane_hit[k])
    );
  end

  assign juego     = SC_COLISION_NV_ESTADO_IN == ESTADO_JUEGO;
  assign inicio    = SC_COLISION_NV_ESTADO_IN == ESTADO_INICIO;
  assign hit_raw   = juego && |lane_hit;
  assign goal_raw  = juego && SC_COLISION_NV_FROG_ROW_IN == 3'(NUM_LANES + 1);
  assign last_life = SC_COLISION_NV_VIDAS_OUT == '0 ||
                     SC_COLISION_NV_VIDAS_OUT == DATAWIDTH_VIDAS'(1);

  always_ff @(posedge SC_COLISION_NV_CLOCK or posedge SC_COLISION_NV_RESET) begin
    if (SC_COLISION_NV_RESET) begin
      state                       <= IDLE;
      cnt                         <= '0;
      SC_COLISION_NV_COLISION_OUT <= 1'b0;
      SC_COLISION_NV_RESPAWN_OUT  <= 1'b0;
      SC_COLISION_NV_META_OUT     <= 1'b0;
      SC_COLISION_NV_VIDAS_OUT    <= DATAWIDTH_VIDAS'(VIDAS_INIT);
      SC_COLISION_NV_GAMEOVER_OUT <= 1'b0;
    end else begin
      SC_COLISION_NV_COLISION_OUT <= 1'b0;
      SC_COLISION_NV_META_OUT     <= 1'b0;
      if (inicio) begin
        state                       <= IDLE;
        cnt                         <= '0;
        SC_COLISION_NV_RESPAWN_OUT  <= 1'b0;
        SC_COLISION_NV_VIDAS_OUT    <= DATAWIDTH_VIDAS'(VIDAS_INIT);
        SC_COLISION_NV_GAMEOVER_OUT <= 1'b0;
      end else begin
        case (state)
          IDLE: if (juego) state <= ARMED;
          ARMED: begin
            if (hit_raw) begin
              SC_COLISION_NV_COLISION_OUT <= 1'b1;
              if (SC_COLISION_NV_VIDAS_OUT != '0)
                SC_COLISION_NV_VIDAS_OUT <= SC_COLISION_NV_VIDAS_OUT - DATAWIDTH_VIDAS'(1);
              if (last_life) begin
                SC_COLISION_NV_GAMEOVER_OUT <= 1'b1;
                state                       <= OVER;
              end else begin
                cnt                        <= CNT_W'(BLANK_CYCLES);
                SC_COLISION_NV_RESPAWN_OUT <= 1'b1;
                state                      <= BLANK;
              end
            end else if (goal_raw) begin
              SC_COLISION_NV_META_OUT <= 1'b1;
              state                   <= GOAL;
            end else if (!juego) begin
              state <= IDLE;
            end
          end
          BLANK: begin
            // Respawn was raised on the hit edge; dropping it as the count leaves 1
            // gives exactly BLANK_CYCLES clocks high.
            if (!juego) begin
              cnt                        <= '0;
              SC_COLISION_NV_RESPAWN_OUT <= 1'b0;
              state                      <= IDLE;
            end else begin
              cnt <= cnt - CNT_W'(1);
              if (cnt <= CNT_W'(1)) begin
                SC_COLISION_NV_RESPAWN_OUT <= 1'b0;
                state                      <= ARMED;
              end
            end
          end
          GOAL: begin
            if (!juego)         state <= IDLE;
            else if (!goal_raw) state <= ARMED;
          end
          OVER:    state <= OVER;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
